// File: rtl/argmax_feeder.sv
// argmax_feeder: producer side of the argmax stream interface.
// Accepts a whole frame of signed accumulator scores through valid/ready,
// requantizes each score to an unsigned DATA_WIDTH value and serializes the
// frame one element per cycle (index 0..CELL_AMOUNT-1) towards an argmax cell.
// A two-slot ping-pong buffer lets back-to-back frames stream without bubbles.
module argmax_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int INDEX_WIDTH = 10,
  parameter int CELL_AMOUNT = 4,
  parameter int SHIFT       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CELL_AMOUNT*ACC_WIDTH-1:0] in_scores,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [INDEX_WIDTH-1:0]           output_index,
  output logic [DATA_WIDTH-1:0]            output_value,
  output logic                             output_enable,
  output logic                             output_last
);

  // Element counter width; CELL_AMOUNT is at least 2 so this is at least 1.
  localparam int CW = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  // Comparison width wide enough to hold both a shifted score and the
  // saturation limit without truncation, whichever of the two is wider.
  localparam int WW = ((ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH) + 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(CELL_AMOUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [WW-1:0] SAT_W    = {{(WW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Arithmetic shift, then clamp into the unsigned DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] score);
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [WW-1:0]               mag;
    logic [DATA_WIDTH-1:0]       res;
    shifted = $signed(score) >>> SHIFT;
    mag     = WW'($unsigned(shifted));
    if (shifted[ACC_WIDTH-1]) begin
      res = {DATA_WIDTH{1'b0}};
    end else if (mag > SAT_W) begin
      res = {DATA_WIDTH{1'b1}};
    end else begin
      res = mag[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  // Frame storage holds already-requantized values, so the read path is a mux.
  logic [DATA_WIDTH-1:0]  slot_q [2][CELL_AMOUNT];
  logic [DATA_WIDTH-1:0]  frame_s [CELL_AMOUNT];

  logic [1:0]             full_q, full_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   ready_q, ready_d;
  logic                   accept_s;
  logic                   free_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc_s;
  // Set on the last-element edge when the other slot already held a frame,
  // which is what allows the next frame to follow with no idle cycle.
  logic                   chain_q, chain_d;

  logic                   emit_s;
  logic [CW-1:0]          emit_idx_s;
  logic                   last_s;

  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [DATA_WIDTH-1:0]  value_q, value_d;
  logic                   enable_q, enable_d;
  logic                   last_q, last_d;

  // Requantize every lane of the incoming frame in parallel.
  always_comb begin
    for (int i = 0; i < CELL_AMOUNT; i++) begin
      frame_s[i] = requant(in_scores[i*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Slot occupancy and pointer bookkeeping; ready reflects next-cycle occupancy only.
  always_comb begin
    accept_s = in_valid & ready_q;
    full_d[0] = (full_q[0] & ~(free_s & (rd_ptr_q == 1'b0))) | (accept_s & (wr_ptr_q == 1'b0));
    full_d[1] = (full_q[1] & ~(free_s & (rd_ptr_q == 1'b1))) | (accept_s & (wr_ptr_q == 1'b1));
    wr_ptr_d  = wr_ptr_q ^ accept_s;
    rd_ptr_d  = rd_ptr_q ^ free_s;
    ready_d   = ~(full_d[0] & full_d[1]);
  end

  // Output FSM: decide which element (if any) is emitted on the coming edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chain_d    = chain_q;
    free_s     = 1'b0;
    emit_s     = 1'b0;
    emit_idx_s = CNT_ZERO;
    last_s     = 1'b0;
    cnt_inc_s  = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_ptr_q]) begin
          emit_s     = 1'b1;
          emit_idx_s = CNT_ZERO;
          cnt_d      = CNT_ZERO;
          state_d    = ST_STREAM;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (cnt_q != LAST_CNT) begin
          emit_s     = 1'b1;
          emit_idx_s = cnt_inc_s;
          cnt_d      = cnt_inc_s;
          if (cnt_inc_s == LAST_CNT) begin
            last_s  = 1'b1;
            free_s  = 1'b1;
            chain_d = full_q[~rd_ptr_q];
          end else begin
            last_s  = 1'b0;
          end
        end else if (chain_q) begin
          // Read pointer has already moved to the waiting frame.
          emit_s     = 1'b1;
          emit_idx_s = CNT_ZERO;
          cnt_d      = CNT_ZERO;
          chain_d    = 1'b0;
        end else begin
          chain_d    = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        chain_d = 1'b0;
      end
    endcase
  end

  // Next values of the registered stream outputs.
  always_comb begin
    if (emit_s) begin
      index_d = INDEX_WIDTH'(emit_idx_s);
      value_d = slot_q[rd_ptr_q][emit_idx_s];
    end else begin
      index_d = {INDEX_WIDTH{1'b0}};
      value_d = {DATA_WIDTH{1'b0}};
    end
    enable_d = emit_s;
    last_d   = last_s;
  end

  // Control state, pointers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      chain_q  <= 1'b0;
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
      index_q  <= {INDEX_WIDTH{1'b0}};
      value_q  <= {DATA_WIDTH{1'b0}};
      enable_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      index_q  <= index_d;
      value_q  <= value_d;
      enable_q <= enable_d;
      last_q   <= last_d;
    end
  end

  // Frame capture into the slot named by the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < CELL_AMOUNT; i++) begin
          slot_q[s][i] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int i = 0; i < CELL_AMOUNT; i++) begin
        slot_q[wr_ptr_q][i] <= frame_s[i];
      end
    end
  end

  // ready_q resets to 1 so the port is high in the first cycle after reset;
  // the reset term keeps it low while reset is held.
  assign in_ready      = ready_q & ~reset;
  assign output_index  = index_q;
  assign output_value  = value_q;
  assign output_enable = enable_q;
  assign output_last   = last_q;

endmodule
